sram_req_adapter: RTL and testbench
===================================

// Module: sram_req_adapter
// PURPOSE
//  Valid/ready front end for the single-port synchronous SRAM macro (en/we/addr/din, 1-cycle
//  registered read data that holds while en is low). Sits directly upstream of the SRAM and
//  turns pipeline read/write requests into SRAM port cycles. Captures read data into a small
//  response buffer, so downstream back-pressure never loses data and throughput stays 1 req/cycle.
// PARAMETERS
//  WIDTH     32   data width, equal to the SRAM WIDTH
//  DEPTH     256  SRAM words; address width AW = $clog2(DEPTH)
//  RSP_DEPTH 2    response buffer entries (>=2); read credit limit
// PORTS
//  clk          in   1      single clock (also drives the SRAM)
//  rst          in   1      asynchronous, active-high reset
//  req_valid_i  in   1      request valid
//  req_ready_o  out  1      request accepted when valid&ready
//  req_we_i     in   1      1 = write, 0 = read
//  req_addr_i   in   AW     word address
//  req_wdata_i  in   WIDTH  write data
//  rsp_valid_o  out  1      read response valid
//  rsp_ready_i  in   1      response consumed when valid&ready
//  rsp_rdata_o  out  WIDTH  read data, in request order
//  sram_en_o    out  1      SRAM enable
//  sram_we_o    out  1      SRAM write enable
//  sram_addr_o  out  AW     SRAM address
//  sram_din_o   out  WIDTH  SRAM write data
//  sram_dout_i  in   WIDTH  SRAM read data (valid the cycle after a read)
// BEHAVIOUR
//  - State: rd_pend (read issued last cycle), FIFO of RSP_DEPTH x WIDTH, count 0..RSP_DEPTH.
//  - While rst=1: rd_pend=0, count=0, FIFO pointers=0, rsp_valid_o=0, req_ready_o=0, sram_en_o=0.
//  - req_ready_o = req_we_i ? 1 : (count + rd_pend < RSP_DEPTH). It does not depend on rsp_ready_i.
//    Writes are always accepted and produce no response.
//  - Issue is combinational: sram_en_o = req_valid_i & req_ready_o; sram_we_o = req_we_i;
//    sram_addr_o/sram_din_o pass req_addr_i/req_wdata_i straight through.
//  - Read accepted in cycle t: rd_pend=1 in t+1, and sram_dout_i is valid in t+1.
//  - rsp_valid_o = rd_pend | (count != 0).
//  - rsp_rdata_o = FIFO head if count != 0, else sram_dout_i (bypass; read latency 1 cycle).
//  - push = rd_pend & ~(count==0 & rsp_ready_i); pop = rsp_ready_i & (count != 0).
//    Push and pop in the same cycle leave count unchanged. Pointers wrap modulo RSP_DEPTH.
//  - The credit rule guarantees push never occurs when count == RSP_DEPTH.
//    The implementation carries an assertion for this.
//  - Ordering: responses leave strictly in read-issue order. Interleaved writes do not reorder them.
//  - Write then read of the same address on consecutive cycles returns the new data.
//    The SRAM provides this; the block has no forwarding logic.
//  - Reset mid-operation: an in-flight read and all buffered data are discarded.
//    No response for them appears after rst deasserts.
// STRUCTURE
//  - Shared package sram_pkg: typedef sram_req_t {we, addr, wdata}, parameterised by WIDTH/DEPTH.
//  - One sub-module: sram_rsp_fifo (sync FIFO, async active-high reset, count output,
//    no fall-through). Bypass muxing and credit logic live in sram_req_adapter.
//  - Bench instantiates sram_req_adapter + sim SRAM model back to back.
// TESTING
//  1 Reset: rst=1 with req_valid_i=1 -> req_ready_o=0, sram_en_o=0, rsp_valid_o=0.
//    After release, req_ready_o=1.
//  2 Write 0x12<-0xDEADBEEF, next cycle read 0x12, rsp_ready_i=1 -> rsp_valid_o=1 one cycle
//    after the read with rsp_rdata_o=0xDEADBEEF.
//  3 Preload addr 0..7 = 0x100+i; 8 back-to-back reads, rsp_ready_i=1 -> req_ready_o stays 1.
//    8 responses on 8 consecutive cycles, 0x100..0x107 in order.
//  4 rsp_ready_i=0, read addr 0,1,2 -> 0 and 1 accepted, req_ready_o=0 for the read of 2.
//    Raise rsp_ready_i -> responses 0x100, 0x101 in order, then read 2 accepted and returned.
//  5 Buffer full (count=2): write 0x5<-0xA5A5A5A5 -> accepted immediately.
//    A later read of 0x5 returns 0xA5A5A5A5.
//  6 Issue a read, assert rst the next cycle -> rsp_valid_o=0 immediately.
//    No response for that read appears after rst deasserts.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared SRAM geometry defaults and request bundle type
package sram_pkg;
    localparam int SRAM_WIDTH = 32;
    localparam int SRAM_DEPTH = 256;
    localparam int SRAM_AW = $clog2(SRAM_DEPTH);
    localparam int SRAM_RSP_DEPTH = 2;
    typedef struct packed {
        logic                  we;
        logic [SRAM_AW-1:0]    addr;
        logic [SRAM_WIDTH-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: registered sync FIFO with occupancy count, head read straight from storage
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
            rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready front end for a 1-cycle SRAM with credit-limited response buffer
module sram_req_adapter
    import sram_pkg::*;
#(
    parameter int WIDTH = SRAM_WIDTH,
    parameter int DEPTH = SRAM_DEPTH,
    parameter int RSP_DEPTH = SRAM_RSP_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [WIDTH-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_rdata_o,
    output logic             sram_en_o,
    output logic             sram_we_o,
    output logic [AW-1:0]    sram_addr_o,
    output logic [WIDTH-1:0] sram_din_o,
    input  logic [WIDTH-1:0] sram_dout_i
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int IW = CW + 1;
    logic             rd_pend, push, pop, empty;
    logic [CW-1:0]    count;
    logic [IW-1:0]    inflight;
    logic [WIDTH-1:0] head;
    always_comb begin
        empty       = count == '0;
        inflight    = IW'(count) + IW'(rd_pend);
        req_ready_o = !rst && (req_we_i || inflight < IW'(RSP_DEPTH));
        sram_en_o   = req_valid_i && req_ready_o;
        sram_we_o   = req_we_i;
        sram_addr_o = req_addr_i;
        sram_din_o  = req_wdata_i;
        push        = rd_pend && !(empty && rsp_ready_i);
        pop         = rsp_ready_i && !empty;
        rsp_valid_o = rd_pend || !empty;
        rsp_rdata_o = empty ? sram_dout_i : head;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= sram_en_o && !req_we_i;
    end
    sram_rsp_fifo #(.WIDTH(WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sram_dout_i),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );
    // Read credits bound occupancy, so a push into a full buffer means the credit logic broke
    assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: directed stimulus with queue scoreboard against a behavioural SRAM
module tb_sram_req_adapter;
    import sram_pkg::*;
    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid_i = 0, req_ready_o, req_we_i = 0;
    logic [7:0]  req_addr_i = 0;
    logic [31:0] req_wdata_i = 0;
    logic        rsp_valid_o, rsp_ready_i = 1;
    logic [31:0] rsp_rdata_o;
    logic        sram_en_o, sram_we_o;
    logic [7:0]  sram_addr_o;
    logic [31:0] sram_din_o, sram_dout_i;
    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_req_adapter dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
    );

    always @(posedge clk) begin
        if (sram_en_o) begin
            if (sram_we_o) mem[sram_addr_o] <= sram_din_o;
            else           sram_dout_i <= mem[sram_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %h with no read outstanding at %0t", rsp_rdata_o, $time);
            end else begin
                chk("rsp_data", rsp_rdata_o, exp_q.pop_front());
            end
        end
    end

    function automatic sram_req_t rq(input logic we, input logic [7:0] a, input logic [31:0] d);
        sram_req_t r;
        r.we = we;
        r.addr = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic issue(input sram_req_t r, input logic [31:0] exp);
        int n = 0;
        req_valid_i = 1;
        req_we_i = r.we;
        req_addr_i = r.addr;
        req_wdata_i = r.wdata;
        @(negedge clk);
        while (!req_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr %h never accepted at %0t", r.addr, $time);
        end else if (!r.we) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        req_valid_i = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1 reset
        req_valid_i = 1;
        @(negedge clk);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_en", sram_en_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        req_we_i = 1;
        #1 chk("rst_ready_wr", req_ready_o, 0);
        @(posedge clk);
        #1;
        rst = 0;
        req_valid_i = 0;
        req_we_i = 0;
        @(negedge clk);
        chk("post_rst_ready", req_ready_o, 1);
        chk("post_rst_rsp_valid", rsp_valid_o, 0);
        step(1);
        // 2 write then read same address
        issue(rq(1, 8'h12, 32'hDEADBEEF), 0);
        issue(rq(0, 8'h12, 0), 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_latency_valid", rsp_valid_o, 1);
        step(2);
        // 3 preload and 8 back-to-back reads
        for (int i = 0; i < 8; i++) issue(rq(1, 8'(i), 32'h100 + i), 0);
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1;
            req_we_i = 0;
            req_addr_i = 8'(i);
            @(negedge clk);
            chk("b2b_ready", req_ready_o, 1);
            if (req_ready_o) exp_q.push_back(32'h100 + i);
            if (i > 0) chk("b2b_rsp_valid", rsp_valid_o, 1);
            step(1);
        end
        req_valid_i = 0;
        @(negedge clk);
        chk("b2b_last_valid", rsp_valid_o, 1);
        step(2);
        // 4 credit limit under back-pressure
        rsp_ready_i = 0;
        issue(rq(0, 8'h0, 0), 32'h100);
        issue(rq(0, 8'h1, 0), 32'h101);
        req_valid_i = 1;
        req_we_i = 0;
        req_addr_i = 8'h2;
        @(negedge clk);
        chk("credit_block", req_ready_o, 0);
        step(1);
        @(negedge clk);
        chk("credit_block_full", req_ready_o, 0);
        chk("stall_valid", rsp_valid_o, 1);
        chk("stall_head", rsp_rdata_o, 32'h100);
        step(1);
        rsp_ready_i = 1;
        issue(rq(0, 8'h2, 0), 32'h102);
        step(2);
        // 5 write accepted while buffer full
        rsp_ready_i = 0;
        issue(rq(0, 8'h3, 0), 32'h103);
        issue(rq(0, 8'h4, 0), 32'h104);
        step(1);
        req_valid_i = 1;
        req_we_i = 1;
        req_addr_i = 8'h5;
        req_wdata_i = 32'hA5A5A5A5;
        @(negedge clk);
        chk("full_wr_ready", req_ready_o, 1);
        chk("full_wr_en", sram_en_o, 1);
        chk("full_wr_we", sram_we_o, 1);
        step(1);
        req_we_i = 0;
        @(negedge clk);
        chk("full_rd_block", req_ready_o, 0);
        step(1);
        rsp_ready_i = 1;
        issue(rq(0, 8'h5, 0), 32'hA5A5A5A5);
        step(3);
        chk("queue_drained", exp_q.size(), 0);
        // 6 reset with a read in flight
        req_valid_i = 1;
        req_we_i = 0;
        req_addr_i = 8'h6;
        @(negedge clk);
        chk("flush_rd_ready", req_ready_o, 1);
        step(1);
        req_valid_i = 0;
        rst = 1;
        @(negedge clk);
        chk("flush_rsp_valid", rsp_valid_o, 0);
        step(2);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_rsp", rsp_valid_o, 0);
            step(1);
        end
        chk("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
